// File: rtl/ps2_pkg.sv
// Shared constants, sequencer state encoding and helpers for the PS/2 keyboard transmitter.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 11;

    typedef enum logic [2:0] {
        IDLE,
        SEND_E0,
        SEND_F0,
        SEND_CODE,
        GAP
    } seq_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte into an 11-bit PS/2 frame; data only changes while ps2_clk is high.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          active;
    logic          clk_low;
    logic [HW-1:0] half_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    frame_sr;
    logic          half_last;

    assign half_last = (half_cnt == HW'(CLK_DIV - 1));

    // done marks the last cycle of the stop bit, so a new byte can load on that same edge
    assign done       = active && clk_low && half_last && (bit_cnt == 4'(PS2_FRAME_BITS - 1));
    assign byte_ready = !active || done;

    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            clk_low  <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            frame_sr <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            active   <= 1'b1;
            clk_low  <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            frame_sr <= {1'b1, odd_parity(byte_data), byte_data};
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b0;
        end else if (done) begin
            active   <= 1'b0;
            clk_low  <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else if (active) begin
            if (!half_last) begin
                half_cnt <= half_cnt + HW'(1);
            end else begin
                half_cnt <= '0;
                if (!clk_low) begin
                    clk_low <= 1'b1;
                    ps2_clk <= 1'b0;
                end else begin
                    clk_low  <= 1'b0;
                    ps2_clk  <= 1'b1;
                    bit_cnt  <= bit_cnt + 4'd1;
                    ps2_data <= frame_sr[0];
                    frame_sr <= {1'b0, frame_sr[9:1]};
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard: queues key events and expands each into E0/F0/code set-2 frames.
module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [7:0] ev_code,
    input  logic       ev_break,
    input  logic       ev_ext,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int GAP_CYCLES = 2 * CLK_DIV;
    localparam int GW         = $clog2(GAP_CYCLES);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    key_event_t    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    key_event_t    head;

    seq_state_t    state, state_next;
    logic          sent, sent_next;
    logic [GW-1:0] gap_cnt, gap_cnt_next;
    logic          cur_brk;
    logic [7:0]    cur_code;

    logic          byte_valid;
    logic          byte_ready;
    logic [7:0]    byte_data;
    logic          done;

    assign ev_ready = !reset && (count != FULL_COUNT);
    assign push     = ev_valid && ev_ready;
    assign head     = fifo_mem[rd_ptr];
    assign busy     = (count != '0) || (state != IDLE);

    // Storage is not reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ev_ext, ev_break, ev_code};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sent     <= 1'b0;
            gap_cnt  <= '0;
            cur_brk  <= 1'b0;
            cur_code <= '0;
        end else begin
            state   <= state_next;
            sent    <= sent_next;
            gap_cnt <= gap_cnt_next;
            if (pop) begin
                cur_brk  <= head.brk;
                cur_code <= head.code;
            end
        end
    end

    // sent records that the current state's byte is already in the serializer; the
    // following byte is handed over on the done edge so frames run back-to-back
    always_comb begin
        state_next   = state;
        sent_next    = sent;
        gap_cnt_next = gap_cnt;
        pop          = 1'b0;
        byte_valid   = 1'b0;
        byte_data    = cur_code;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    sent_next = 1'b0;
                    if (head.code == 8'h00) begin
                        state_next = IDLE;
                    end else if (head.ext) begin
                        state_next = SEND_E0;
                    end else if (head.brk) begin
                        state_next = SEND_F0;
                    end else begin
                        state_next = SEND_CODE;
                    end
                end
            end
            SEND_E0: begin
                if (!sent) begin
                    byte_valid = 1'b1;
                    byte_data  = PS2_EXT_PREFIX;
                    sent_next  = byte_ready;
                end else if (done) begin
                    byte_valid = 1'b1;
                    byte_data  = cur_brk ? PS2_BREAK_PREFIX : cur_code;
                    state_next = cur_brk ? SEND_F0 : SEND_CODE;
                end
            end
            SEND_F0: begin
                if (!sent) begin
                    byte_valid = 1'b1;
                    byte_data  = PS2_BREAK_PREFIX;
                    sent_next  = byte_ready;
                end else if (done) begin
                    byte_valid = 1'b1;
                    byte_data  = cur_code;
                    state_next = SEND_CODE;
                end
            end
            SEND_CODE: begin
                if (!sent) begin
                    byte_valid = 1'b1;
                    byte_data  = cur_code;
                    sent_next  = byte_ready;
                end else if (done) begin
                    state_next   = GAP;
                    sent_next    = 1'b0;
                    gap_cnt_next = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    ps2_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_tx (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .done       (done),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data)
    );

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Scoreboard bench: events expand into expected byte lists; a monitor decodes PS/2 frames off the wire.
module tb_ps2_keyboard_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int BIT_CYC    = 2 * CLK_DIV;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       ev_valid = 1'b0;
    logic [7:0] ev_code  = 8'h00;
    logic       ev_break = 1'b0;
    logic       ev_ext   = 1'b0;
    logic       ev_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    ps2_keyboard_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_break (ev_break),
        .ev_ext   (ev_ext),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   abort_req  = 0;
    int   mon_nbits  = 0;
    int   mon_falls  = 0;
    int   mon_frames = 0;

    task automatic checkOutput(input string name, input integer actual, input integer expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one event, wait for the handshake, and record the bytes it should produce
    task automatic applyStimulus(input logic [7:0] code, input logic brk, input logic ext,
                                 output int acc_cyc);
        bit ok;
        bit first;
        int waited;
        waited = 0;
        first  = 1'b1;
        @(negedge clk);
        ev_code  = code;
        ev_break = brk;
        ev_ext   = ext;
        ev_valid = 1'b1;
        forever begin
            ok = ev_ready;
            @(posedge clk);
            if (ok) break;
            waited++;
            if (waited > 2000) break;
            @(negedge clk);
        end
        #1 ev_valid = 1'b0;
        acc_cyc = cyc;
        if (!ok) begin
            checkOutput("accept_timeout", 0, 1);
        end else if (code != 8'h00) begin
            if (ext) begin
                exp_q.push_back('{data: 8'hE0, first: first});
                first = 1'b0;
            end
            if (brk) begin
                exp_q.push_back('{data: 8'hF0, first: first});
                first = 1'b0;
            end
            exp_q.push_back('{data: code, first: first});
        end
    endtask

    task automatic waitIdle(input int limit, output int fall_cyc);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy !== 1'b0 && n < limit);
        checkOutput("idle_reached", 32'(busy), 0);
        fall_cyc = cyc;
    endtask

    // Decodes frames on falling ps2_clk edges and checks widths, spacing and contents
    task automatic monitorFrames();
        logic       prev_clk;
        logic       low_data;
        bit         low_changed;
        bit         have_prev;
        logic [10:0] bits;
        int         low_len;
        int         nb;
        int         last_fall;
        int         abort_seen;
        exp_t       e;
        prev_clk    = 1'b1;
        low_data    = 1'b1;
        low_changed = 1'b0;
        have_prev   = 1'b0;
        bits        = '0;
        low_len     = 0;
        nb          = 0;
        last_fall   = 0;
        abort_seen  = 0;
        forever begin
            @(negedge clk);
            if (abort_seen != abort_req) begin
                abort_seen = abort_req;
                nb         = 0;
                have_prev  = 1'b0;
                low_len    = 0;
                prev_clk   = ps2_clk;
                mon_nbits  = 0;
                continue;
            end
            if (prev_clk && !ps2_clk) begin
                mon_falls++;
                if (have_prev) begin
                    if (nb == 0 && exp_q.size() > 0 && exp_q[0].first)
                        checkOutput("event_spacing_min", 32'((cyc - last_fall) >= 4 * CLK_DIV + 2), 1);
                    else
                        checkOutput("bit_spacing", cyc - last_fall, BIT_CYC);
                end
                last_fall   = cyc;
                have_prev   = 1'b1;
                bits[nb]    = ps2_data;
                nb++;
                low_len     = 1;
                low_data    = ps2_data;
                low_changed = 1'b0;
                if (nb == 11) begin
                    nb = 0;
                    checkOutput("start_bit", 32'(bits[0]), 0);
                    checkOutput("stop_bit", 32'(bits[10]), 1);
                    checkOutput("parity_odd", $countones(bits[9:1]) % 2, 1);
                    checkOutput("frame_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checkOutput("frame_byte", 32'(bits[8:1]), 32'(e.data));
                    end
                    mon_frames++;
                end
            end else if (!ps2_clk) begin
                low_len++;
                if (ps2_data !== low_data) low_changed = 1'b1;
            end else if (!prev_clk && ps2_clk) begin
                checkOutput("low_width", low_len, CLK_DIV);
                checkOutput("data_stable_low", 32'(low_changed), 0);
            end
            prev_clk  = ps2_clk;
            mon_nbits = nb;
        end
    endtask

    initial begin
        int acc, acc0, acc1, fall, n, f;
        int acc_q[$];

        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready_in_reset", 32'(ev_ready), 0);
        reset = 1'b0;
        #1;
        checkOutput("reset_ps2_clk", 32'(ps2_clk), 1);
        checkOutput("reset_ps2_data", 32'(ps2_data), 1);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_ready", 32'(ev_ready), 1);

        fork
            monitorFrames();
        join_none

        // Lone press 0x1C: start bit two edges after accept, 88-cycle frame, 8-cycle gap
        applyStimulus(8'h1C, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        checkOutput("latency_pre_start", 32'(ps2_data), 1);
        @(posedge clk); #1;
        checkOutput("latency_start_bit", 32'(ps2_data), 0);
        checkOutput("latency_start_clk", 32'(ps2_clk), 1);
        f = mon_frames;
        waitIdle(500, fall);
        checkOutput("press_busy_fall", fall - acc, 2 + 24 * CLK_DIV);
        checkOutput("press_frame_count", mon_frames - f, 1);

        applyStimulus(8'h1C, 1'b1, 1'b0, acc);
        waitIdle(500, fall);
        checkOutput("release_busy_fall", fall - acc, 2 + 46 * CLK_DIV);

        applyStimulus(8'h75, 1'b1, 1'b1, acc);
        waitIdle(800, fall);
        checkOutput("ext_release_busy_fall", fall - acc, 2 + 68 * CLK_DIV);

        // Ten events offered back-to-back against an eight-deep queue
        for (int i = 0; i < 9; i++) begin
            if (i == 0) applyStimulus(8'h75, 1'b1, 1'b1, acc);
            else        applyStimulus(8'(8'h10 + i), 1'b0, 1'b0, acc);
            acc_q.push_back(acc);
        end
        checkOutput("ready_when_full", 32'(ev_ready), 0);
        applyStimulus(8'h4A, 1'b0, 1'b0, acc);
        checkOutput("accept_after_pop", acc - acc_q[0], 4 + 68 * CLK_DIV);
        waitIdle(20000, fall);
        checkOutput("fifo_burst_drained", exp_q.size(), 0);

        // A 0x00 event is dropped without a gap; only its pop cycle is lost
        applyStimulus(8'h00, 1'b1, 1'b1, acc);
        waitIdle(50, fall);
        checkOutput("zero_busy_fall", fall - acc, 1);
        applyStimulus(8'h00, 1'b0, 1'b0, acc0);
        applyStimulus(8'h1C, 1'b0, 1'b0, acc1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ps2_data !== 1'b0 && n < 100);
        checkOutput("zero_then_press_start", cyc - acc0, 3);
        waitIdle(500, fall);

        // One-cycle reset in the middle of a frame
        applyStimulus(8'h5A, 1'b0, 1'b0, acc);
        n = 0;
        while (mon_nbits != 6 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checkOutput("reach_bit5", 32'(n < 500), 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("ready_during_reset", 32'(ev_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        abort_req++;
        checkOutput("abort_ps2_clk", 32'(ps2_clk), 1);
        checkOutput("abort_ps2_data", 32'(ps2_data), 1);
        checkOutput("abort_busy", 32'(busy), 0);
        f = mon_falls;
        repeat (120) @(posedge clk);
        #1;
        checkOutput("abort_no_falls", mon_falls - f, 0);
        checkOutput("abort_still_idle", 32'(busy), 0);

        // Randomized events with random idle spacing
        for (int i = 0; i < 25; i++) begin
            logic [7:0] code;
            code = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            applyStimulus(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        waitIdle(30000, fall);
        checkOutput("random_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
